// File: rtl/sha256_digest_acc_if.sv
// sha256_digest_acc_if: block handoff, chaining-hash and digest handshake signals of the digest accumulator.
interface sha256_digest_acc_if;
  logic         init;
  logic         acc_valid;
  logic         acc_last;
  logic         acc_ready;
  logic [31:0]  in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H;
  logic [255:0] h_out;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         busy;
  modport master (
    output init, acc_valid, acc_last, in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H, digest_ready,
    input  acc_ready, h_out, digest_valid, digest, busy
  );
  modport slave (
    input  init, acc_valid, acc_last, in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H, digest_ready,
    output acc_ready, h_out, digest_valid, digest, busy
  );
endinterface

// File: rtl/sha256_digest_acc.sv
// sha256_digest_acc: adds final working variables into the chaining hash and presents the digest after the last block.
module sha256_digest_acc #(
  parameter int ADDS_PER_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  sha256_digest_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        accept, acc_done;
  logic [31:0] h_q [8];
  logic [31:0] h_d [8];
  logic [31:0] s_q [8];
  logic [31:0] s_d [8];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= 1'b0;
      h_q     <= IV;
      s_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end
  always_comb begin
    accept   = bus.acc_ready && bus.acc_valid;
    acc_done = state_q == ACC && idx_q == 3'(8 - ADDS_PER_CYC);
    state_d  = state_q == IDLE ? (accept ? ACC : IDLE) :
               state_q == ACC  ? (acc_done ? (last_q ? OUT : IDLE) : ACC) :
               (bus.digest_ready ? IDLE : OUT);
    idx_d    = state_q == ACC ? idx_q + 3'(ADDS_PER_CYC) : '0;
    last_d   = accept ? bus.acc_last : last_q;
    s_d      = s_q;
    if (accept) s_d = '{bus.in_A, bus.in_B, bus.in_C, bus.in_D, bus.in_E, bus.in_F, bus.in_G, bus.in_H};
    // idx advances in whole groups, so word k belongs to the group being added when k/N == idx/N
    for (int k = 0; k < 8; k++)
      h_d[k] = (state_q == IDLE && bus.init) ? IV[k] :
               (state_q == ACC && k / ADDS_PER_CYC == int'(idx_q) / ADDS_PER_CYC) ? h_q[k] + s_q[k] : h_q[k];
  end
  assign bus.acc_ready    = state_q == IDLE && !bus.init && rst_n;
  assign bus.h_out        = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  assign bus.digest_valid = state_q == OUT;
  assign bus.digest       = bus.digest_valid ? bus.h_out : '0;
  assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_sha256_digest_acc.sv
// tb_sha256_digest_acc: directed blocks against a word-level hash model, plus literal digests for FIPS vectors.
module tb_sha256_digest_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sha256_digest_acc_if bus ();
  sha256_digest_acc_if bus4 ();
  sha256_digest_acc #(.ADDS_PER_CYC(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  sha256_digest_acc #(.ADDS_PER_CYC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IVM1    = 256'h6a09e666_bb67ae84_3c6ef371_a54ff539_510e527e_9b05688b_1f83d9aa_5be0cd18;
  localparam logic [255:0] ABC_IN  = 256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ALL_F   = {8{32'hffffffff}};
  localparam logic [255:0] ALL_1   = {8{32'h00000001}};
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [31:0] iv_w [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  int          m_st;
  int          m_cnt;
  logic        m_last;
  logic [31:0] m_h [8];
  logic [31:0] m_start [8];
  logic [31:0] m_fin [8];
  logic [255:0] inv;
  function automatic logic [255:0] pack_h();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[255-32*k -: 32] = m_h[k];
    return r;
  endfunction
  // model: a block's final hash is fixed at acceptance; during ACC the first cnt words already show it
  always @(posedge clk or negedge rst_n) begin
    inv = {bus.in_A, bus.in_B, bus.in_C, bus.in_D, bus.in_E, bus.in_F, bus.in_G, bus.in_H};
    if (!rst_n) begin
      m_st <= 0;
      m_h  <= iv_w;
    end else if (m_st == 0) begin
      if (bus.init) m_h <= iv_w;
      else if (bus.acc_valid) begin
        for (int k = 0; k < 8; k++) begin
          m_start[k] <= m_h[k];
          m_fin[k]   <= m_h[k] + inv[255-32*k -: 32];
        end
        m_last <= bus.acc_last;
        m_cnt  <= 0;
        m_st   <= 1;
      end
    end else if (m_st == 1) begin
      for (int k = 0; k < 8; k++) m_h[k] <= (k < m_cnt + 1) ? m_fin[k] : m_start[k];
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == 8) m_st <= m_last ? 2 : 0;
    end else if (bus.digest_ready) m_st <= 0;
  end
  always @(posedge clk) begin
    #1;
    chk("h_out", bus.h_out, pack_h());
    chk("digest_valid", 256'(bus.digest_valid), 256'(m_st == 2));
    chk("digest", bus.digest, m_st == 2 ? pack_h() : '0);
    chk("busy", 256'(bus.busy), 256'(m_st != 0));
    chk("acc_ready", 256'(bus.acc_ready), 256'(m_st == 0 && !bus.init && rst_n));
  end
  task automatic set_in(input logic [255:0] v);
    {bus.in_A, bus.in_B, bus.in_C, bus.in_D, bus.in_E, bus.in_F, bus.in_G, bus.in_H} = v;
  endtask
  task automatic pulse_init();
    @(negedge clk) bus.init = 1'b1;
    @(negedge clk) bus.init = 1'b0;
  endtask
  task automatic send_block(input logic [255:0] v, input logic last);
    logic ok = 1'b0;
    @(negedge clk);
    bus.acc_valid = 1'b1;
    bus.acc_last  = last;
    set_in(v);
    for (int i = 0; i < 10 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      #1 ok = bus.acc_ready;
      @(posedge clk);
    end
    chk("accepted", 256'(ok), 256'(1));
    #2;
    bus.acc_valid = 1'b0;
    set_in({8{$urandom}});
  endtask
  task automatic wait_digest(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1 cnt++;
    end while (!bus.digest_valid && cnt < 20);
  endtask
  task automatic release_digest();
    @(negedge clk) bus.digest_ready = 1'b1;
    @(posedge clk);
    #1 chk("released", 256'(bus.digest_valid), 256'(0));
    @(negedge clk) bus.digest_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    bus.init = 0; bus.acc_valid = 0; bus.acc_last = 0; bus.digest_ready = 0; set_in('0);
    bus4.init = 0; bus4.acc_valid = 0; bus4.acc_last = 0; bus4.digest_ready = 0;
    {bus4.in_A, bus4.in_B, bus4.in_C, bus4.in_D, bus4.in_E, bus4.in_F, bus4.in_G, bus4.in_H} = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_h_out", bus.h_out, IV);
    chk("rst_acc_ready", 256'(bus.acc_ready), 256'(0));
    chk("rst_digest", bus.digest, '0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_ready", 256'(bus.acc_ready), 256'(1));
    // zero block: digest equals IV, held until ready
    pulse_init();
    send_block('0, 1'b1);
    wait_digest(cnt);
    chk("lat1", 256'(cnt), 256'(8));
    chk("zero_digest", bus.digest, IV);
    repeat (3) begin
      @(posedge clk);
      #1 chk("hold_digest", bus.digest, IV);
    end
    release_digest();
    // "abc"
    pulse_init();
    send_block(ABC_IN, 1'b1);
    wait_digest(cnt);
    chk("abc_digest", bus.digest, ABC_DIG);
    chk("model_abc", pack_h(), ABC_DIG);
    release_digest();
    // wraparound, non-last then last
    pulse_init();
    send_block(ALL_F, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("wrap_h", bus.h_out, IVM1);
    chk("wrap_busy", 256'(bus.busy), 256'(0));
    chk("wrap_valid", 256'(bus.digest_valid), 256'(0));
    send_block(ALL_1, 1'b1);
    wait_digest(cnt);
    chk("two_block_digest", bus.digest, IV);
    release_digest();
    // init beats acc_valid
    pulse_init();
    @(negedge clk);
    bus.init = 1'b1; bus.acc_valid = 1'b1; bus.acc_last = 1'b1; set_in(ABC_IN);
    #1 chk("prio_ready", 256'(bus.acc_ready), 256'(0));
    @(posedge clk);
    #1;
    chk("prio_busy", 256'(bus.busy), 256'(0));
    chk("prio_h", bus.h_out, IV);
    @(negedge clk) bus.init = 1'b0;
    #1 chk("held_ready", 256'(bus.acc_ready), 256'(1));
    @(posedge clk);
    #1 chk("held_busy", 256'(bus.busy), 256'(1));
    bus.acc_valid = 1'b0;
    wait_digest(cnt);
    chk("held_digest", bus.digest, ABC_DIG);
    release_digest();
    // reset mid-ACC
    pulse_init();
    send_block(ABC_IN, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_busy", 256'(bus.busy), 256'(0));
    chk("midrst_h", bus.h_out, IV);
    chk("midrst_valid", 256'(bus.digest_valid), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("midrst_never", 256'(bus.digest_valid), 256'(0));
    // four adds per cycle
    @(negedge clk) bus4.init = 1'b1;
    @(negedge clk) bus4.init = 1'b0;
    @(negedge clk);
    bus4.acc_valid = 1'b1; bus4.acc_last = 1'b1;
    {bus4.in_A, bus4.in_B, bus4.in_C, bus4.in_D, bus4.in_E, bus4.in_F, bus4.in_G, bus4.in_H} = ABC_IN;
    #1 chk("p4_ready", 256'(bus4.acc_ready), 256'(1));
    @(posedge clk);
    #2;
    bus4.acc_valid = 1'b0;
    {bus4.in_A, bus4.in_B, bus4.in_C, bus4.in_D, bus4.in_E, bus4.in_F, bus4.in_G, bus4.in_H} = '1;
    cnt = 0;
    do begin
      @(posedge clk);
      #1 cnt++;
    end while (!bus4.digest_valid && cnt < 20);
    chk("p4_lat", 256'(cnt), 256'(2));
    chk("p4_digest", bus4.digest, ABC_DIG);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("p4_hold", bus4.digest, ABC_DIG);
      chk("p4_hold_valid", 256'(bus4.digest_valid), 256'(1));
    end
    @(negedge clk) bus4.digest_ready = 1'b1;
    @(posedge clk);
    #1 chk("p4_release", 256'(bus4.busy), 256'(0));
    bus4.digest_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
